// File: rtl/test_pattern_checker_pkg.sv
// Shared definitions for the storage test-pattern generator/checker pair.
package test_pattern_checker_pkg;

    // Checker synchronisation states
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Increment between consecutive pattern words; generator and checker both use this
    localparam int DEFAULT_STEP = 43;

endpackage

// File: rtl/test_pattern_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 aclr_n,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] count
);

    // Clear wins over increment; increment stops once the counter is full
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + CNT_WIDTH'(1);
    end

endmodule

// File: rtl/test_pattern_checker.sv
// Read-back checker for the storage test-pattern stream: hunts for the
// +STEP sequence, locks after a run of matches, then tracks it without
// reseeding so single corrupted words are flagged but do not shift alignment.
module test_pattern_checker
    import test_pattern_checker_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int STEP        = DEFAULT_STEP,
    parameter int LOCK_RUN    = 4,
    parameter int LOSS_THRESH = 8,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 aclr_n,
    input  logic                 ena,
    input  logic [WIDTH-1:0]     val,
    input  logic                 resync,
    output logic                 locked,
    output logic                 err,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic [CNT_WIDTH-1:0] word_count
);

    // Run counters only need to reach THRESH-1 before the transition fires
    localparam int GW = (LOCK_RUN    > 1) ? $clog2(LOCK_RUN)    : 1;
    localparam int BW = (LOSS_THRESH > 1) ? $clog2(LOSS_THRESH) : 1;
    localparam logic [GW-1:0]    GOOD_LAST = GW'(LOCK_RUN - 1);
    localparam logic [BW-1:0]    BAD_LAST  = BW'(LOSS_THRESH - 1);
    localparam logic [WIDTH-1:0] STEP_W    = WIDTH'(STEP);

    state_t          state;
    logic [WIDTH-1:0] expected;
    logic [GW-1:0]   good_run;
    logic [BW-1:0]   bad_run;

    logic match;
    logic track;

    assign match = (val == expected);
    assign track = ena && !resync && (state == LOCKED);

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_err_cnt (
        .clk    (clk),
        .aclr_n (aclr_n),
        .inc    (track && !match),
        .clr    (resync),
        .count  (err_count)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_word_cnt (
        .clk    (clk),
        .aclr_n (aclr_n),
        .inc    (track),
        .clr    (resync),
        .count  (word_count)
    );

    // Synchronisation FSM with expected-value tracking and registered flags
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state    <= HUNT;
            expected <= '0;
            good_run <= '0;
            bad_run  <= '0;
            locked   <= 1'b0;
            err      <= 1'b0;
        end else if (resync) begin
            // The coincident word is dropped; the next valid word seeds the hunt
            state    <= HUNT;
            good_run <= '0;
            bad_run  <= '0;
            locked   <= 1'b0;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            if (ena) begin
                case (state)
                    HUNT: begin
                        expected <= val + STEP_W;
                        good_run <= '0;
                        state    <= VERIFY;
                    end
                    VERIFY: begin
                        // Mismatch reseeds from the data; match extends the run
                        expected <= val + STEP_W;
                        if (match) begin
                            if (good_run == GOOD_LAST) begin
                                state    <= LOCKED;
                                locked   <= 1'b1;
                                good_run <= '0;
                                bad_run  <= '0;
                            end else begin
                                good_run <= good_run + GW'(1);
                            end
                        end else begin
                            good_run <= '0;
                        end
                    end
                    LOCKED: begin
                        // Free-running expectation: never realigned from data
                        expected <= expected + STEP_W;
                        if (match) begin
                            bad_run <= '0;
                        end else begin
                            err <= 1'b1;
                            if (bad_run == BAD_LAST) begin
                                state   <= HUNT;
                                locked  <= 1'b0;
                                bad_run <= '0;
                            end else begin
                                bad_run <= bad_run + BW'(1);
                            end
                        end
                    end
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_test_pattern_checker.sv
// Directed + randomized bench for test_pattern_checker with a stream-level model.
module tb_test_pattern_checker;

    localparam int WIDTH       = 16;
    localparam int STEP        = 43;
    localparam int LOCK_RUN    = 4;
    localparam int LOSS_THRESH = 8;
    localparam int CNT_WIDTH   = 4;   // small so saturation is reached quickly
    localparam int CMAX        = (1 << CNT_WIDTH) - 1;

    logic                 clk = 1'b0;
    logic                 aclr_n = 1'b0;
    logic                 ena = 1'b0;
    logic [WIDTH-1:0]     val = '0;
    logic                 resync = 1'b0;
    logic                 locked;
    logic                 err;
    logic [CNT_WIDTH-1:0] err_count;
    logic [CNT_WIDTH-1:0] word_count;

    int errors = 0;
    int checks = 0;

    test_pattern_checker #(
        .WIDTH(WIDTH), .STEP(STEP), .LOCK_RUN(LOCK_RUN),
        .LOSS_THRESH(LOSS_THRESH), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk(clk), .aclr_n(aclr_n), .ena(ena), .val(val), .resync(resync),
        .locked(locked), .err(err), .err_count(err_count), .word_count(word_count)
    );

    always #5 clk = ~clk;

    // Reference model: "hunting" counts consecutive +STEP pairs among valid
    // words; once locked, the n-th word after the lock word must equal
    // anchor + n*STEP regardless of what the data did in between.
    bit         m_hunt;
    bit         have_prev;
    logic [15:0] prev;
    int         run;
    logic [15:0] anchor;
    int         n;
    int         misses;
    bit         m_locked, m_err;
    int         m_ec, m_wc;

    task automatic model_reset();
        m_hunt = 1; have_prev = 0; run = 0; n = 0; misses = 0;
        m_locked = 0; m_err = 0; m_ec = 0; m_wc = 0; prev = '0; anchor = '0;
    endtask

    task automatic model(input logic e, input logic [15:0] v, input logic r);
        logic [15:0] want;
        if (r) begin
            m_hunt = 1; have_prev = 0; run = 0;
            m_ec = 0; m_wc = 0; m_locked = 0; m_err = 0;
        end else if (!e) begin
            m_err = 0;
        end else if (m_hunt) begin
            m_err = 0;
            if (!have_prev) begin
                have_prev = 1; run = 0;
            end else if (v == 16'(prev + 16'(STEP))) begin
                run++;
                if (run == LOCK_RUN) begin
                    m_hunt = 0; m_locked = 1; anchor = v; n = 0; misses = 0;
                end
            end else begin
                run = 0;
            end
            prev = v;
        end else begin
            n++;
            want = 16'(anchor + 16'(n * STEP));
            if (m_wc < CMAX) m_wc++;
            if (v == want) begin
                misses = 0; m_err = 0;
            end else begin
                m_err = 1;
                if (m_ec < CMAX) m_ec++;
                misses++;
                if (misses == LOSS_THRESH) begin
                    m_hunt = 1; have_prev = 0; run = 0; m_locked = 0;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".locked"},     32'(locked),     32'(m_locked));
        chk({tag, ".err"},        32'(err),        32'(m_err));
        chk({tag, ".err_count"},  32'(err_count),  32'(m_ec));
        chk({tag, ".word_count"}, 32'(word_count), 32'(m_wc));
    endtask

    task automatic step(input logic e, input logic [15:0] v, input logic r);
        @(negedge clk);
        ena = e; val = v; resync = r;
        @(posedge clk);
        model(e, v, r);
        #1;
        chk_all("step");
    endtask

    task automatic send(input logic [15:0] v);
        step(1'b1, v, 1'b0);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 16'($urandom), 1'b0);
    endtask

    logic [15:0] w;

    initial begin
        model_reset();
        #12;
        chk_all("reset");
        @(negedge clk);
        aclr_n = 1'b1;

        // Clean stream locks after seed + 4 matches
        send(16'd0); send(16'd43); send(16'd86); send(16'd129);
        chk("not_locked_yet", 32'(locked), 32'd0);
        send(16'd172);
        chk("lock_after_172", 32'(locked), 32'd1);
        chk("no_err_clean", 32'(err_count), 32'd0);

        // Single corrupted word: one err pulse, alignment kept
        send(16'h1234);
        chk("err_pulse", 32'(err), 32'd1);
        chk("err_count_1", 32'(err_count), 32'd1);
        send(16'd258);
        chk("no_reseed_258", 32'(err), 32'd0);
        chk("still_locked", 32'(locked), 32'd1);
        send(16'd301);

        // Eight garbage words force a relock
        w = 16'd344;
        for (int i = 0; i < LOSS_THRESH; i++) begin
            send(w ^ 16'h5555);
            chk("garbage_err", 32'(err), 32'd1);
            w += 16'(STEP);
        end
        chk("lost_lock", 32'(locked), 32'd0);
        chk("err_count_9", 32'(err_count), 32'd9);
        for (int i = 0; i < 4; i++) begin send(w); w += 16'(STEP); end
        chk("relock_pending", 32'(locked), 32'd0);
        send(w); w += 16'(STEP);
        chk("relocked", 32'(locked), 32'd1);

        // Wrap through zero with idle gaps
        step(1'b0, 16'h0000, 1'b1);
        chk("resync_clears_wc", 32'(word_count), 32'd0);
        w = 16'hFFC5 - 16'd215;
        for (int i = 0; i < 9; i++) begin
            idle($urandom_range(0, 3));
            send(w);
            w += 16'(STEP);
        end
        chk("wrap_word_count", 32'(word_count), 32'd4);
        chk("wrap_no_err", 32'(err_count), 32'd0);
        chk("wrap_val_end", 32'(w), 32'h0071);

        // resync with a coincident word while locked and err_count=3
        for (int i = 0; i < 3; i++) begin send(w ^ 16'h00FF); w += 16'(STEP); end
        chk("err_count_3", 32'(err_count), 32'd3);
        step(1'b1, w, 1'b1);
        chk("resync_unlock", 32'(locked), 32'd0);
        chk("resync_ec", 32'(err_count), 32'd0);
        chk("resync_wc", 32'(word_count), 32'd0);
        for (int i = 0; i < 4; i++) begin w += 16'(STEP); send(w); end
        chk("coincident_not_seed", 32'(locked), 32'd0);
        w += 16'(STEP); send(w);
        chk("resync_relock", 32'(locked), 32'd1);

        // Asynchronous reset mid-stream
        w += 16'(STEP); send(w);
        w += 16'(STEP); send(w ^ 16'h0001);
        chk("pre_reset_err", 32'(err), 32'd1);
        @(negedge clk);
        ena = 1'b0;
        #2 aclr_n = 1'b0;
        #1;
        model_reset();
        chk_all("async_reset");
        @(negedge clk);
        aclr_n = 1'b1;
        w = 16'h7A00;
        for (int i = 0; i < 5; i++) begin send(w); w += 16'(STEP); end
        chk("post_reset_lock", 32'(locked), 32'd1);

        // Randomized stream: gaps, corruption, bursts, slips, resyncs
        begin
            int burst = 0;
            logic e, r, bad;
            logic [15:0] v;
            for (int i = 0; i < 2000; i++) begin
                r = ($urandom_range(0, 149) == 0);
                e = ($urandom_range(0, 3) != 0);
                if (burst == 0 && $urandom_range(0, 99) == 0) burst = $urandom_range(5, 10);
                if ($urandom_range(0, 199) == 0) w = 16'($urandom);
                bad = (burst > 0) || ($urandom_range(0, 19) == 0);
                v = bad ? 16'($urandom) : w;
                step(e, v, r);
                if (e && !r) begin
                    w += 16'(STEP);
                    if (burst > 0) burst--;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/test_pattern_checker.md
Name: test_pattern_checker

Overview:
Receive-side partner of the storage test-pattern generator. Consumes words that were written by the generator and read back through the memory/FIFO under test. Checks that successive valid words advance by STEP modulo 2^WIDTH. Self-synchronises to the stream, reports lock status, flags mismatches and keeps saturating error/word statistics for the storage test harness.

Parameters:
WIDTH, 16, data word width; must match the generator
STEP, 43, expected increment between consecutive valid words
LOCK_RUN, 4, consecutive matches needed to declare lock (>=1)
LOSS_THRESH, 8, consecutive mismatches while locked that force a relock (>=1)
CNT_WIDTH, 16, width of the error and word counters

Ports:
clk  in  1  clock; all logic on the rising edge
aclr_n  in  1  asynchronous active-low reset
ena  in  1  val carries a valid word this cycle
val  in  WIDTH  pattern word read back from storage
resync  in  1  synchronous request to drop lock and re-hunt
locked  out  1  checker is locked to the stream
err  out  1  one-cycle pulse: a locked word mismatched
err_count  out  CNT_WIDTH  mismatches seen while locked, saturating
word_count  out  CNT_WIDTH  words checked while locked, saturating

Behaviour:
- One clock domain. Reset is asynchronous and active-low (aclr_n).
- Reset values: state=HUNT, expected=0, run counters=0, locked=0, err=0, err_count=0, word_count=0. Deassertion of reset is used as-is; synchronisation is done outside this block.
- All outputs are registered.
- Arithmetic is modulo 2^WIDTH. Example with WIDTH=16: 16'hFFF0 + 43 = 16'h001B.
- When ena=0, all state is held and err=0.
- resync=1 has the highest priority after reset:
  - next state is HUNT; err_count, word_count and both run counters are cleared; locked=0.
  - any word presented in the same cycle is discarded.
- States:
  - HUNT: on ena, expected <= val+STEP, good_run <= 0, go to VERIFY.
  - VERIFY: on ena with val==expected: good_run increments.
    - If good_run reaches LOCK_RUN-1 before the increment, go to LOCKED and clear bad_run.
    - expected <= val+STEP.
  - VERIFY: on ena with a mismatch: expected <= val+STEP (reseed), good_run <= 0, stay in VERIFY.
  - VERIFY raises no err and changes no counters.
  - LOCKED: on every ena, expected <= expected+STEP. The stream is never reseeded from data, so one corrupted word does not shift alignment. word_count increments, saturating.
  - LOCKED, match: bad_run <= 0.
  - LOCKED, mismatch: err pulses in the next cycle, err_count increments (saturating at all-ones), and bad_run increments. If bad_run was LOSS_THRESH-1, go to HUNT; locked drops in the next cycle, and err_count and word_count are kept.
- Latency:
  - locked rises in the cycle after the clock edge that samples the LOCK_RUN-th consecutive match. Counting the HUNT seed word, that is LOCK_RUN+1 valid words.
  - err is high for exactly the one cycle after the edge that samples the bad word.
- Boundaries:
  - Counters stay at 2^CNT_WIDTH-1 once saturated.
  - Wrap of val through zero is a normal match.
  - With LOCK_RUN=1, the first match after the seed locks.
  - With LOSS_THRESH=1, any locked mismatch relocks, and err still pulses.

Decomposition:
- Shared storage-test package holds:
  - the state encoding (HUNT, VERIFY, LOCKED) as a typedef;
  - the default STEP=43 constant, so generator and checker share one definition.
- One natural sub-module: sat_counter (CNT_WIDTH, inc, clr, saturating output). It is instantiated twice, for err_count and word_count.
- The FSM and the expected-value register stay in the top level.

Test Plan:
- Reset, then a clean stream 0, 43, 86, 129, 172 with ena=1 -> locked=1 in the cycle after 172 is sampled; err never high; err_count=0.
- Locked stream, one word 215 replaced by 0x1234, then 258 continues -> err pulses once; err_count=1; locked stays 1; the 258 word matches with no reseed.
- Locked stream, 8 consecutive garbage words -> 8 err pulses; err_count=8; locked=0 after the 8th; clean words then relock after 5 more valid words.
- Stream crossing the wrap 0xFFC5 -> 0xFFF0 -> 0x001B -> 0x0046 with ena gaps of 0-3 idle cycles between words -> no err; word_count counts only valid words.
- resync asserted with ena=1 while locked and err_count=3 -> next cycle locked=0, err_count=0, word_count=0; the coincident word is not used as the seed.
- aclr_n pulsed low mid-stream while locked with counters nonzero -> all outputs 0 immediately (asynchronously); after release, the checker hunts and relocks on the following words.
